// File: rtl/alu_nand_sweep_checker.sv
// Exhaustive operand sweep for the NAND ALU slice.
// Compares each result against the golden NAND and latches the first failure.
module alu_nand_sweep_checker #(
    parameter int W          = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    output logic [W-1:0]   op_a,
    output logic [W-1:0]   op_b,
    input  logic [2*W-1:0] res_in,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*W:0]   err_cnt,
    output logic           fail_valid,
    output logic [W-1:0]   ff_a,
    output logic [W-1:0]   ff_b,
    output logic [2*W-1:0] ff_res
);

    localparam int RW = 2 * W;
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYC - 1);
    localparam logic [RW:0] ERR_MAX = {1'b1, {RW{1'b0}}};

    generate
        if (SETTLE_CYC < 1) begin : g_bad_settle
            $error("SETTLE_CYC must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic [RW-1:0] golden;
    logic          mism;
    logic          last;
    logic          go;

    assign go     = start & ((state == IDLE) | (state == DONE));
    assign golden = {{W{1'b0}}, ~(op_a & op_b)};
    assign mism   = (res_in != golden);
    assign last   = (&op_a) & (&op_b);

    assign busy = (state == SETTLE) | (state == CHECK);
    assign done = (state == DONE);
    assign pass = done & (err_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = SETTLE;
            SETTLE: begin
                if (abort)          state_nxt = IDLE;
                else if (cnt == '0) state_nxt = CHECK;
            end
            CHECK: begin
                if (abort)     state_nxt = IDLE;
                else if (last) state_nxt = DONE;
                else           state_nxt = SETTLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Abort takes precedence over the check in the cycle it lands on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            cnt        <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            ff_a       <= '0;
            ff_b       <= '0;
            ff_res     <= '0;
        end else if (go) begin
            op_a       <= '0;
            op_b       <= '0;
            cnt        <= RELOAD;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            ff_a       <= '0;
            ff_b       <= '0;
            ff_res     <= '0;
        end else if (state == SETTLE && !abort) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
        end else if (state == CHECK && !abort) begin
            if (mism) begin
                if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    ff_a       <= op_a;
                    ff_b       <= op_b;
                    ff_res     <= res_in;
                end
            end
            if (!last) begin
                {op_a, op_b} <= {op_a, op_b} + 1'b1;
                cnt          <= RELOAD;
            end
        end
    end

endmodule

// File: tb/tb_alu_nand_sweep_checker.sv
// Randomised and directed sweeps of the NAND sweep checker
// against a loop-based model of the expected outcome.
module tb_alu_nand_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v [2];
    logic       abort_v [2];
    logic [3:0] op_a_v  [2];
    logic [3:0] op_b_v  [2];
    logic [7:0] res_v   [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic       pass_v  [2];
    logic [8:0] err_v   [2];
    logic       fv_v    [2];
    logic [3:0] ffa_v   [2];
    logic [3:0] ffb_v   [2];
    logic [7:0] ffr_v   [2];
    int         mode_v  [2];

    logic       flt_mask [256];
    logic [7:0] flt_xor  [256];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_nand_sweep_checker #(.W(4), .SETTLE_CYC(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .op_a(op_a_v[0]), .op_b(op_b_v[0]), .res_in(res_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_cnt(err_v[0]), .fail_valid(fv_v[0]),
        .ff_a(ffa_v[0]), .ff_b(ffb_v[0]), .ff_res(ffr_v[0])
    );

    alu_nand_sweep_checker #(.W(4), .SETTLE_CYC(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .op_a(op_a_v[1]), .op_b(op_b_v[1]), .res_in(res_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_cnt(err_v[1]), .fail_valid(fv_v[1]),
        .ff_a(ffa_v[1]), .ff_b(ffb_v[1]), .ff_res(ffr_v[1])
    );

    // Behaviour of the (possibly faulty) slice feeding the checker.
    function automatic logic [7:0] slice(input int mode,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
        logic [7:0] r;
        r = {4'h0, ~(a & b)};
        case (mode)
            1: r[0] = 1'b0;
            2: r[4] = 1'b1;
            3: if (a == 4'd5 && b == 4'd3) r = 8'h00;
            4: if (flt_mask[{a, b}]) r = r ^ flt_xor[{a, b}];
            default: ;
        endcase
        return r;
    endfunction

    always_comb begin
        res_v[0] = slice(mode_v[0], op_a_v[0], op_b_v[0]);
        res_v[1] = slice(mode_v[1], op_a_v[1], op_b_v[1]);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outcome after the first npairs pairs of a sweep.
    task automatic model(input int mode, input int npairs,
                         output int errs, output logic fv,
                         output logic [3:0] fa, output logic [3:0] fb,
                         output logic [7:0] fr);
        logic [7:0] obs, good;
        errs = 0; fv = 0; fa = 0; fb = 0; fr = 0;
        for (int i = 0; i < npairs; i++) begin
            good = {4'h0, 4'hF & ~(4'(i >> 4) & 4'(i))};
            obs  = slice(mode, 4'(i >> 4), 4'(i));
            if (obs != good) begin
                if (errs < 256) errs++;
                if (!fv) begin
                    fv = 1; fa = 4'(i >> 4); fb = 4'(i); fr = obs;
                end
            end
        end
    endtask

    task automatic check_results(input int sel, input int mode,
                                 input int npairs, input string tag);
        int errs;
        logic fv;
        logic [3:0] fa, fb;
        logic [7:0] fr;
        model(mode, npairs, errs, fv, fa, fb, fr);
        check({tag, ".err"},  64'(err_v[sel]), 64'(errs));
        check({tag, ".fv"},   64'(fv_v[sel]),  64'(fv));
        check({tag, ".ffab"}, 64'({ffa_v[sel], ffb_v[sel]}), 64'({fa, fb}));
        check({tag, ".ffres"}, 64'(ffr_v[sel]), 64'(fr));
    endtask

    task automatic run_sweep(input int sel, input int mode, input int s,
                             input string tag);
        int cycles = 0;
        int guard = 0;
        int seq_bad = 0;
        int errs;
        logic fv;
        logic [3:0] fa, fb;
        logic [7:0] fr;
        mode_v[sel] = mode;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        while (!done_v[sel] && guard < 5000) begin
            if (busy_v[sel]) begin
                if ({op_a_v[sel], op_b_v[sel]} != 8'(cycles / (s + 1)))
                    seq_bad++;
                cycles++;
            end
            @(negedge clk);
            guard++;
        end
        check({tag, ".timeout"}, 64'(guard < 5000), 64'd1);
        check({tag, ".busycyc"}, 64'(cycles), 64'(256 * (s + 1)));
        check({tag, ".seq"}, 64'(seq_bad), 64'd0);
        check({tag, ".done"}, 64'({done_v[sel], busy_v[sel]}), 64'b10);
        model(mode, 256, errs, fv, fa, fb, fr);
        check({tag, ".pass"}, 64'(pass_v[sel]), 64'(errs == 0));
        check_results(sel, mode, 256, tag);
    endtask

    task automatic run_abort(input int mode);
        int cycles = 0;
        int guard = 0;
        int seq_bad = 0;
        mode_v[0] = mode;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        while (cycles < 101 && guard < 1000) begin
            if (busy_v[0]) begin
                if ({op_a_v[0], op_b_v[0]} != 8'(cycles / 2)) seq_bad++;
                cycles++;
            end
            start_v[0] = (cycles == 50);
            if (cycles < 101) @(negedge clk);
            guard++;
        end
        // Abort in the SETTLE of pair 50, with a competing start.
        abort_v[0] = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        start_v[0] = 1'b0;
        check("abort.seq", 64'(seq_bad), 64'd0);
        check("abort.idle", 64'({busy_v[0], done_v[0], pass_v[0]}), 64'd0);
        repeat (3) @(negedge clk);
        check("abort.stay", 64'({busy_v[0], done_v[0]}), 64'd0);
        check("abort.ops", 64'({op_a_v[0], op_b_v[0]}), 64'd50);
        check_results(0, mode, 50, "abort");
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 0; abort_v[i] = 0; mode_v[i] = 0;
        end
        for (int i = 0; i < 256; i++) begin
            flt_mask[i] = ($urandom_range(0, 7) == 0);
            flt_xor[i]  = 8'($urandom_range(1, 255));
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            check("reset", 64'({busy_v[i], done_v[i], pass_v[i], fv_v[i],
                   err_v[i], op_a_v[i], op_b_v[i], ffa_v[i], ffb_v[i],
                   ffr_v[i]}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(0, 0, 1, "good");
        run_sweep(0, 1, 1, "bit0lo");
        check("bit0lo.cnt", 64'(err_v[0]), 64'd192);
        run_sweep(0, 2, 1, "bit4hi");
        check("bit4hi.sat", 64'({err_v[0], ffr_v[0]}), {47'd0, 9'd256, 8'h1F});
        run_sweep(0, 3, 1, "single");
        check("single.ff", 64'({ffa_v[0], ffb_v[0], ffr_v[0]}), 64'h5300);
        run_sweep(0, 0, 1, "rerun");
        run_sweep(0, 4, 1, "rand");
        run_abort(1);
        run_sweep(0, 0, 1, "postabort");

        // Asynchronous reset between clock edges in the middle of a sweep.
        mode_v[0] = 1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (200) @(negedge clk);
        check("prereset.busy", 64'(busy_v[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset", 64'({busy_v[0], done_v[0], pass_v[0], fv_v[0],
              err_v[0], op_a_v[0], op_b_v[0], ffa_v[0], ffb_v[0],
              ffr_v[0]}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(1, 0, 3, "settle3");
        run_sweep(1, 4, 3, "settle3rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_nand_sweep_checker.md
Name: alu_nand_sweep_checker

Overview:
- Sequential stimulus-and-check engine for the team's 4-bit NAND ALU slice; it is the consumer of that slice's 8-bit zero-extended result bus.
- Drives every operand pair {A, B} into the slice, waits a fixed settle time, samples the result and compares it against the golden value.
- Reports pass/fail, the error count and the first failing vector.
- Lets the exhaustive sweep run in synthesised hardware as a built-in self-test, not only in simulation.

Parameters:
- W, 4, operand width. Result width is 2*W. Sweep length is 2^(2*W) pairs.
- SETTLE_CYC, 1, cycles each operand pair is held before sampling. Must be >= 1; elaboration error otherwise.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a sweep; sampled only in IDLE or DONE
- abort  input  1  synchronous abort of a running sweep
- op_a  output  W  operand A to the ALU slice
- op_b  output  W  operand B to the ALU slice
- res_in  input  2*W  result bus from the ALU slice
- busy  output  1  high in SETTLE and CHECK
- done  output  1  high in DONE; held until the next start
- pass  output  1  done and err_cnt==0
- err_cnt  output  2*W+1  count of mismatching pairs; saturates at 2^(2*W)
- fail_valid  output  1  first-fail registers hold a captured vector
- ff_a, ff_b  output  W  operands of the first mismatch
- ff_res  output  2*W  res_in observed at the first mismatch

Behaviour:
- Reset: asynchronous, active-low. State goes to IDLE; every output and register clears to 0, including op_a and op_b.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE with start=1:
  - op_a, op_b, err_cnt, fail_valid, ff_a, ff_b and ff_res are cleared.
  - Settle counter loads SETTLE_CYC-1.
  - Next state is SETTLE.
- SETTLE:
  - Operands are held; the counter decrements.
  - Moves to CHECK on the cycle the counter is 0. SETTLE therefore lasts exactly SETTLE_CYC cycles.
- CHECK (exactly 1 cycle):
  - Expected value is {W zero bits, ~(op_a & op_b)}.
  - If res_in != expected, err_cnt increments (saturating).
  - On the first mismatch only, ff_a/ff_b/ff_res capture the current op_a/op_b/res_in and fail_valid is set.
  - Any nonzero upper half of res_in is a mismatch.
- CHECK exit:
  - If op_a and op_b are both all-ones, next state is DONE.
  - Otherwise op_b increments. When op_b wraps from all-ones to 0, op_a increments: B is the inner loop, A the outer.
  - Counter reloads; next state is SETTLE.
- Timing: each pair costs SETTLE_CYC+1 cycles. A full sweep is busy for 2^(2*W)*(SETTLE_CYC+1) cycles; for the defaults that is 512.
- done: rises on the first cycle after the final CHECK. pass is combinational from the DONE state and err_cnt.
- start while busy: ignored.
- abort while busy: returns to IDLE next cycle. done stays 0. err_cnt and first-fail registers are retained. Operands hold their last values.
- abort with start in IDLE/DONE: abort has no effect; start wins.
- abort in IDLE/DONE otherwise: no effect.
- Reset mid-sweep: immediate return to IDLE with all outputs 0; no partial results are kept.
- res_in is sampled only in CHECK; its value in any other state is don't-care.

Test Plan:
1. Correct NAND slice connected, defaults, pulse start → busy for exactly 512 cycles, then done=1, pass=1, err_cnt=0, fail_valid=0; op_a/op_b follow the sequence (0,0),(0,1)…(0,F),(1,0)…(F,F).
2. res_in[0] forced to 0 → done after 512 cycles; err_cnt=192; ff_a=0, ff_b=0, ff_res=8'h0E; pass=0.
3. res_in[4] forced to 1 → err_cnt=256 (no wrap); ff_res=8'h1F at (0,0).
4. Single fault: res_in=8'h00 only when op_a=5 and op_b=3 → err_cnt=1; ff_a=5, ff_b=3, ff_res=8'h00. A second start clears the result fields and, with the fault removed, gives pass=1.
5. Pulse abort at busy cycle 100 → IDLE next cycle, done=0, busy=0. Start during a run and start on the abort cycle are both ignored.
6. Drop rst_n low mid-sweep, asynchronously between edges → all outputs 0 immediately. After release, start runs a full sweep with SETTLE_CYC=3 in 1024 cycles and pass=1.
